// File: rtl/sr_ff_bank_if.sv
// sr_ff_bank_if -- bundle of the control, request and status signals of sr_ff_bank.
//
// Parameters
//   WIDTH : number of S-R channels
//   CNT_W : width of the conflict counter
//
// Signals
//   en       : update enable (driver -> bank)
//   clr      : synchronous clear, wins over en (driver -> bank)
//   s, r     : per-channel set / reset requests (driver -> bank)
//   q        : registered channel state (bank -> driver)
//   qn       : bitwise inverse of q (bank -> driver)
//   chg      : per-channel "q changed on the last edge" flags (bank -> driver)
//   conflict : some channel saw s=r=1 on the last enabled edge (bank -> driver)
//   conf_cnt : saturating count of conflict edges (bank -> driver)
//
// Modports
//   master : the side that issues requests
//   slave  : the flip-flop bank itself
interface sr_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             en;
  logic             clr;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] chg;
  logic             conflict;
  logic [CNT_W-1:0] conf_cnt;

  modport master (
    output en, clr, s, r,
    input  q, qn, chg, conflict, conf_cnt
  );

  modport slave (
    input  en, clr, s, r,
    output q, qn, chg, conflict, conf_cnt
  );

endinterface

// File: rtl/sr_ff_bank.sv
// sr_ff_bank -- a bank of WIDTH independent S-R flip-flops with change flags and a
// saturating conflict counter.
//
// Parameters
//   WIDTH : number of channels (1..64)
//   MODE  : behaviour when s=r=1 on a channel: 0 hold, 1 set, 2 reset, 3 toggle;
//           any other value behaves as 0
//   CNT_W : width of the conflict counter (1..32)
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset; clears every register immediately
//   bus   : sr_ff_bank_if slave modport
//             en, clr, s, r             -> requests
//             q, qn, chg, conflict,
//             conf_cnt                  <- status
//
// Edge priority is rst_n, then clr, then en, then hold. Every output other than qn
// comes straight from a flop; qn is only an inverter on q, so no request input
// reaches any output combinationally.
module sr_ff_bank #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sr_ff_bank_if.slave  bus
);

  // Out-of-range MODE values collapse onto "hold".
  localparam int MODE_EFF = (MODE >= 0 && MODE <= 3) ? MODE : 0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] chg_reg;
  logic             conflict_reg;
  logic             conflict_hit;
  logic [CNT_W-1:0] cnt_reg;

  // Enabled next state of every channel. The s=r=1 resolution is elaborated
  // from MODE, so only one resolution path exists in hardware.
  always_comb begin
    q_next = q_reg;
    for (int i = 0; i < WIDTH; i++) begin
      case ({bus.s[i], bus.r[i]})
        2'b10:   q_next[i] = 1'b1;
        2'b01:   q_next[i] = 1'b0;
        2'b11: begin
          case (MODE_EFF)
            1:       q_next[i] = 1'b1;
            2:       q_next[i] = 1'b0;
            3:       q_next[i] = ~q_reg[i];
            default: q_next[i] = q_reg[i];
          endcase
        end
        default: q_next[i] = q_reg[i];
      endcase
    end
  end

  assign conflict_hit = |(bus.s & bus.r);

  // chg always reflects old q XOR new q. A clear edge therefore reports every
  // bit that was set, and a disabled edge reports nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg        <= '0;
      chg_reg      <= '0;
      conflict_reg <= 1'b0;
      cnt_reg      <= '0;
    end else if (bus.clr) begin
      q_reg        <= '0;
      chg_reg      <= q_reg;
      conflict_reg <= 1'b0;
      cnt_reg      <= '0;
    end else if (bus.en) begin
      q_reg        <= q_next;
      chg_reg      <= q_reg ^ q_next;
      conflict_reg <= conflict_hit;
      // The counter sticks at all-ones; only clr or reset bring it back.
      if (conflict_hit && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      chg_reg      <= '0;
      conflict_reg <= 1'b0;
    end
  end

  assign bus.q        = q_reg;
  assign bus.qn       = ~q_reg;
  assign bus.chg      = chg_reg;
  assign bus.conflict = conflict_reg;
  assign bus.conf_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank -- scoreboard bench for sr_ff_bank.
//
// Five banks share one stimulus stream: MODE 0..3 with an 8-bit counter, plus a
// MODE 1 bank with a 4-bit counter so saturation is reached quickly. The driver
// predicts each edge from a mask-level reference model and queues the
// expectation; a monitor pops one entry after every rising edge that has one.
module tb_sr_ff_bank;

  localparam int NB = 5;

  typedef struct packed {
    logic [NB-1:0][7:0] q;
    logic [NB-1:0][7:0] chg;
    logic [NB-1:0]      conf;
    logic [NB-1:0][7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en_drv;
  logic       clr_drv;
  logic [7:0] s_drv;
  logic [7:0] r_drv;

  logic [7:0] q_all    [NB];
  logic [7:0] qn_all   [NB];
  logic [7:0] chg_all  [NB];
  logic       conf_all [NB];
  logic [7:0] cnt_all  [NB];

  exp_t        exp_q [$];
  logic [7:0]  mq    [NB];
  int unsigned mcnt  [NB];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < NB; g++) begin : gen_bank
    localparam int BW = (g == 4) ? 4 : 8;
    localparam int BM = (g == 4) ? 1 : g;

    sr_ff_bank_if #(.WIDTH(8), .CNT_W(BW)) bus ();

    assign bus.en  = en_drv;
    assign bus.clr = clr_drv;
    assign bus.s   = s_drv;
    assign bus.r   = r_drv;

    assign q_all[g]    = bus.q;
    assign qn_all[g]   = bus.qn;
    assign chg_all[g]  = bus.chg;
    assign conf_all[g] = bus.conflict;
    assign cnt_all[g]  = 8'(bus.conf_cnt);

    sr_ff_bank #(.WIDTH(8), .MODE(BM), .CNT_W(BW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  function automatic int mode_of(int k);
    return (k == 4) ? 1 : k;
  endfunction

  function automatic int unsigned cnt_max(int k);
    return (k == 4) ? 15 : 255;
  endfunction

  // Reference next state from set/clear masks rather than per-bit cases.
  function automatic logic [7:0] model_next(logic [7:0] q, logic [7:0] s,
                                            logic [7:0] r, int mode);
    logic [7:0] only_s;
    logic [7:0] only_r;
    logic [7:0] both;
    logic [7:0] base;
    only_s = s & ~r;
    only_r = r & ~s;
    both   = s & r;
    base   = (q | only_s) & ~only_r;
    case (mode)
      1:       return base | both;
      2:       return base & ~both;
      3:       return base ^ both;
      default: return base;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      mq[k]   = 8'h00;
      mcnt[k] = 0;
    end
  endtask

  task automatic cmp(input string name, input int k, input logic [7:0] act,
                     input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s bank%0d got=%h expected=%h at %0t", name, k, act, want, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    for (int k = 0; k < NB; k++) begin
      cmp("q",        k, q_all[k],          e.q[k]);
      cmp("qn",       k, qn_all[k],         ~e.q[k]);
      cmp("chg",      k, chg_all[k],        e.chg[k]);
      cmp("conflict", k, {7'd0, conf_all[k]}, {7'd0, e.conf[k]});
      cmp("conf_cnt", k, cnt_all[k],        e.cnt[k]);
    end
  endtask

  task automatic applyStimulus(input logic en_i, input logic clr_i,
                               input logic [7:0] s_i, input logic [7:0] r_i);
    exp_t       e;
    logic [7:0] nq;
    logic       cf;
    @(negedge clk);
    en_drv  = en_i;
    clr_drv = clr_i;
    s_drv   = s_i;
    r_drv   = r_i;
    e = '0;
    for (int k = 0; k < NB; k++) begin
      if (clr_i) begin
        nq      = 8'h00;
        cf      = 1'b0;
        mcnt[k] = 0;
      end else if (en_i) begin
        nq = model_next(mq[k], s_i, r_i, mode_of(k));
        cf = (s_i & r_i) != 8'h00;
        if (cf && mcnt[k] < cnt_max(k)) mcnt[k]++;
      end else begin
        nq = mq[k];
        cf = 1'b0;
      end
      e.q[k]    = nq;
      e.chg[k]  = mq[k] ^ nq;
      e.conf[k] = cf;
      e.cnt[k]  = 8'(mcnt[k]);
      mq[k]     = nq;
    end
    exp_q.push_back(e);
  endtask

  task automatic resetCheck();
    exp_t e;
    e = '0;
    checkOutput(e);
  endtask

  // Drop reset between edges, confirm immediate clearing, hold it across a few
  // edges with random requests, then release with a no-op request pending.
  task automatic asyncReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    resetCheck();
    model_reset();
    repeat (3) begin
      @(negedge clk);
      en_drv  = 1'b1;
      clr_drv = 1'($urandom_range(0, 1));
      s_drv   = 8'($urandom);
      r_drv   = 8'($urandom);
      @(posedge clk);
      #2;
      resetCheck();
    end
    @(negedge clk);
    en_drv  = 1'b0;
    clr_drv = 1'b0;
    rst_n   = 1'b1;
  endtask

  // Monitor: one scoreboard entry per rising edge that has a prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic [7:0] sv;
    rst_n   = 1'b0;
    en_drv  = 1'b0;
    clr_drv = 1'b0;
    s_drv   = 8'h00;
    r_drv   = 8'h00;
    model_reset();
    #12;
    resetCheck();
    @(negedge clk);
    rst_n = 1'b1;

    // Set low nibble twice: second edge reports no change.
    applyStimulus(1'b1, 1'b0, 8'h0F, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h0F, 8'h00);
    // Full conflict from q=0F: each bank resolves per its MODE.
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);

    // Disabled edge ignores a full conflict.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h55, 8'hAA);
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'hFF);

    // Build q=3C with five conflict edges, then clear with requests present.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h3C, 8'hC3);
    repeat (5) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00 | 8'h00) ;
    repeat (5) applyStimulus(1'b1, 1'b0, 8'h80, 8'h80);
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'h00);

    // Saturation: 4-bit bank must stop at 15.
    repeat (20) applyStimulus(1'b1, 1'b0, 8'h01, 8'h01);

    // Reset while saturated and holding q=A5.
    applyStimulus(1'b1, 1'b0, 8'hA5, 8'h5A);
    asyncReset();

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      sv = 8'($urandom);
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                    sv, 8'($urandom) & (($urandom_range(0, 1) != 0) ? sv : 8'hFF));
    end

    // Reset while a clear is being held.
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'h00);
    asyncReset();
    applyStimulus(1'b1, 1'b0, 8'hC3, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
SR_FF_BANK -- requirements
Module: sr_ff_bank

Interface
REQ-001 Parameter WIDTH, 8: number of independent S-R channels, legal range 1..64.
REQ-002 Parameter MODE, 0: S=R=1 resolution; 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle; any other value behaves as 0.
REQ-003 Parameter CNT_W, 8: width of the conflict counter, legal range 1..32.
REQ-004 CLK  input  1  clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 EN  input  1  update enable; when 0, Q holds.
REQ-007 CLR  input  1  synchronous clear; priority over EN.
REQ-008 S  input  WIDTH  per-channel set request.
REQ-009 R  input  WIDTH  per-channel reset request.
REQ-010 Q  output  WIDTH  registered channel state.
REQ-011 QN  output  WIDTH  combinational bitwise inverse of Q.
REQ-012 CHG  output  WIDTH  registered; bit i = 1 for one cycle after an edge on which Q[i] changed.
REQ-013 CONFLICT  output  1  registered; 1 for one cycle after an enabled edge on which any channel had S=R=1.
REQ-014 CONF_CNT  output  CNT_W  saturating count of enabled edges with CONFLICT set.

Function
REQ-015 Per-bit priority on each rising edge with RST=1: CLR, then EN, then hold.
REQ-016 CLR=1: Q<=0, CHG<=old Q, CONFLICT<=0, CONF_CNT<=0; S, R and EN are ignored.
REQ-017 CLR=0, EN=1, per bit: S=0 R=0 hold; S=1 R=0 Q<=1; S=0 R=1 Q<=0; S=1 R=1 per MODE.
REQ-018 S=R=1 with MODE 0: hold; MODE 1: Q<=1; MODE 2: Q<=0; MODE 3: Q<=~Q.
REQ-019 CLR=0, EN=0: Q, CONF_CNT hold; CHG<=0; CONFLICT<=0.
REQ-020 CHG<=old Q XOR new Q on every edge, including CLR edges.
REQ-021 CONFLICT<=OR over bits of (S AND R) when CLR=0 and EN=1, else 0.
REQ-022 CONF_CNT increments by 1 on each edge that sets CONFLICT.
REQ-023 CONF_CNT stops at 2^CNT_W-1 (no wrap); only CLR or RST returns it to 0.
REQ-024 Single-cycle latency: every request takes effect on Q at the first rising edge that samples it.
REQ-025 Channels are fully independent; a conflict on one channel does not affect any other channel's Q.
REQ-026 No combinational path from S, R, EN or CLR to any output; QN depends only on Q.

Reset
REQ-027 RST=0 forces, immediately and without a clock edge: Q=0, QN=all ones, CHG=0, CONFLICT=0, CONF_CNT=0.
REQ-028 All outputs hold reset values while RST=0, regardless of CLK, EN, CLR, S and R.
REQ-029 On the first rising edge after RST rises, the block operates normally per REQ-015.
REQ-030 RST asserting mid-operation, including mid-saturation or during CLR, overrides all state at once.

Verification (WIDTH=8, CNT_W=8, MODE=0 unless stated)
REQ-031 Q=0xA5, drop RST between edges -> Q=0x00, QN=0xFF, CONF_CNT=0 before the next edge.
REQ-032 Q=0x00, EN=1, S=0x0F, R=0x00 -> edge 1: Q=0x0F, CHG=0x0F; edge 2 with same inputs: Q=0x0F, CHG=0x00.
REQ-033 Q=0x0F, EN=1, S=R=0xFF, one edge per MODE -> MODE0: Q=0x0F; MODE1: Q=0xFF; MODE2: Q=0x00; MODE3: Q=0xF0. Each run: CONFLICT=1, CONF_CNT +1.
REQ-034 CNT_W=4, 20 consecutive enabled S=R=0x01 edges -> CONF_CNT reaches 15 and holds at 15; CONFLICT=1 on every cycle.
REQ-035 Q=0x3C, CONF_CNT=5, CLR=1, EN=1, S=0xFF -> Q=0x00, CHG=0x3C, CONFLICT=0, CONF_CNT=0.
REQ-036 Q=0x55, EN=0, S=0xFF, R=0xFF -> Q=0x55, CHG=0x00, CONFLICT=0, CONF_CNT unchanged.
